// File: rtl/bch_dvbs2_pkg.sv
// Shared constants and types for the DVB-S2 normal-frame BCH generator ROM path.
package bch_dvbs2_pkg;

  localparam int DATA_W     = 192;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 3;
  localparam int WORDS_T8   = 16;
  localparam int WORDS_T10  = 20;
  localparam int WORDS_T12  = 24;

  // t_sel encodings
  localparam logic [1:0] T8   = 2'd0;
  localparam logic [1:0] T10  = 2'd1;
  localparam logic [1:0] T12  = 2'd2;
  localparam logic [1:0] TRSV = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bch_rom_capture_fifo.sv
// Shift-register capture FIFO: entry 0 is the registered head, flush empties it at once.
module bch_rom_capture_fifo #(
  parameter int W     = 193,
  parameter int DEPTH = 3
) (
  input  logic                         clk_1x,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 head,
  output logic                         head_vld,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem, mem_n;
  logic [DEPTH-1:0]        vld, vld_n;
  logic [CW-1:0]           cnt, cnt_n, wr_idx;
  logic                    push_g, pop_g;

  assign pop_g  = pop && vld[0];
  assign push_g = push && ((cnt < CW'(DEPTH)) || pop_g);
  assign wr_idx = pop_g ? cnt - CW'(1) : cnt;

  always_comb begin
    mem_n = mem;
    vld_n = vld;
    if (pop_g) begin
      for (int i = 0; i < DEPTH-1; i++) begin
        mem_n[i] = mem[i+1];
        vld_n[i] = vld[i+1];
      end
      vld_n[DEPTH-1] = 1'b0;
    end
    // New word lands behind the last valid entry, after any shift.
    if (push_g) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_idx == CW'(i)) begin
          mem_n[i] = din;
          vld_n[i] = 1'b1;
        end
      end
    end
    cnt_n = cnt + CW'(push_g) - CW'(pop_g);
  end

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst) begin
      mem <= '0;
      vld <= '0;
      cnt <= '0;
    end else if (flush) begin
      vld <= '0;
      cnt <= '0;
    end else begin
      mem <= mem_n;
      vld <= vld_n;
      cnt <= cnt_n;
    end
  end

  assign head     = mem[0];
  assign head_vld = vld[0];
  assign count    = cnt;

endmodule

// File: rtl/bch_gen_rom_sched.sv
// BCH generator ROM scheduler: walks one ROM, absorbs its 1-cycle latency, streams words out.
// Build option BCH_GEN_ROM_SCHED_REVERSE_EN walks addresses N-1..0 instead of 0..N-1.
module bch_gen_rom_sched
  import bch_dvbs2_pkg::*;
#(
  parameter int DATA_W     = bch_dvbs2_pkg::DATA_W,
  parameter int ADDR_W     = bch_dvbs2_pkg::ADDR_W,
  parameter int FIFO_DEPTH = bch_dvbs2_pkg::FIFO_DEPTH,
  parameter int WORDS_T8   = bch_dvbs2_pkg::WORDS_T8,
  parameter int WORDS_T10  = bch_dvbs2_pkg::WORDS_T10,
  parameter int WORDS_T12  = bch_dvbs2_pkg::WORDS_T12
) (
  input  logic              clk_1x,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        t_sel,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err_tsel,
  output logic [1:0]        rom_sel,
  output logic              rom_rd_en,
  output logic [ADDR_W-1:0] rom_rdaddr,
  input  logic [DATA_W-1:0] rom_rd_q,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last
);

  localparam int CW  = ADDR_W + 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  state_e          state, state_n;
  logic [CW-1:0]   n_words, words_sel, issued, accepted;
  logic [FCW-1:0]  fifo_cnt;
  logic            inflight, inflight_last;
  logic            start_ok, start_bad, issue, xfer, last_xfer, flush;
  logic [DATA_W:0] head_word;

  always_comb begin
    case (t_sel)
      T8:      words_sel = CW'(WORDS_T8);
      T10:     words_sel = CW'(WORDS_T10);
      T12:     words_sel = CW'(WORDS_T12);
      default: words_sel = '0;
    endcase
  end

  assign start_ok  = (state == S_IDLE) && start && !abort && (t_sel != TRSV);
  assign start_bad = (state == S_IDLE) && start && !abort && (t_sel == TRSV);
  assign flush     = abort && (state != S_IDLE);
  assign xfer      = m_valid && m_ready;
  assign last_xfer = xfer && (accepted == n_words - CW'(1));

  // Credit counts the buffered words plus the read still in the ROM pipe,
  // so a capture can never find the buffer full.
  assign issue = (state == S_RUN) && !abort && (issued < n_words) &&
                 ((int'(fifo_cnt) + int'(inflight)) < FIFO_DEPTH);

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start_ok) state_n = S_RUN;
      S_RUN: begin
        if (abort)          state_n = S_IDLE;
        else if (last_xfer) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == S_RUN);
    done       = (state == S_DONE);
    rom_rd_en  = issue;
    rom_rdaddr = '0;
    if (issue) begin
`ifdef BCH_GEN_ROM_SCHED_REVERSE_EN
      rom_rdaddr = ADDR_W'(n_words - CW'(1) - issued);
`else
      rom_rdaddr = issued[ADDR_W-1:0];
`endif
    end
  end

  always_ff @(posedge clk_1x or posedge rst) begin
    if (rst) begin
      n_words       <= '0;
      rom_sel       <= '0;
      issued        <= '0;
      accepted      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_tsel      <= 1'b0;
    end else begin
      err_tsel      <= start_bad;
      inflight      <= issue;
      // The final issued read is the last word in both address orders.
      inflight_last <= issue && (issued == n_words - CW'(1));
      if (start_ok) begin
        n_words  <= words_sel;
        rom_sel  <= t_sel;
        issued   <= '0;
        accepted <= '0;
      end else begin
        if (issue) issued   <= issued + CW'(1);
        if (xfer)  accepted <= accepted + CW'(1);
      end
    end
  end

  bch_rom_capture_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_1x   (clk_1x),
    .rst      (rst),
    .flush    (flush),
    .push     (inflight),
    .din      ({inflight_last, rom_rd_q}),
    .pop      (xfer),
    .head     (head_word),
    .head_vld (m_valid),
    .count    (fifo_cnt)
  );

  assign m_data = head_word[DATA_W-1:0];
  assign m_last = head_word[DATA_W] && m_valid;

endmodule

// File: tb/tb_bch_gen_rom_sched.sv
// Randomized bench for bch_gen_rom_sched against a transaction-level model of the ROM walk.
module tb_bch_gen_rom_sched;

  localparam int DW = 192;
  localparam int AW = 5;
  localparam int FD = 3;

  logic          clk_1x = 1'b0;
  logic          rst = 1'b1, start = 1'b0, abort = 1'b0, m_ready = 1'b0;
  logic [1:0]    t_sel = 2'd0;
  logic          busy, done, err_tsel, rom_rd_en, m_valid, m_last;
  logic [1:0]    rom_sel;
  logic [AW-1:0] rom_rdaddr;
  logic [DW-1:0] rom_rd_q, m_data;

  bch_gen_rom_sched dut (
    .clk_1x(clk_1x), .rst(rst), .start(start), .t_sel(t_sel), .abort(abort),
    .busy(busy), .done(done), .err_tsel(err_tsel), .rom_sel(rom_sel),
    .rom_rd_en(rom_rd_en), .rom_rdaddr(rom_rdaddr), .rom_rd_q(rom_rd_q),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
  );

  always #5 clk_1x = ~clk_1x;

  int errors = 0, checks = 0;
  logic [DW-1:0] rom_mem [0:3][0:31];

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk_1x) if (rom_rd_en) rom_rd_q <= rom_mem[rom_sel][rom_rdaddr];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int n_of(input logic [1:0] t);
    return (t == 2'd0) ? 16 : (t == 2'd1) ? 20 : 24;
  endfunction

  function automatic int exp_addr(input int n, input int i);
`ifdef BCH_GEN_ROM_SCHED_REVERSE_EN
    return n - 1 - i;
`else
    return i;
`endif
  endfunction

  // Model: ph 0 idle, 1 sequence running, 2 completion cycle.
  int cyc = 0, ph = 0, mn = 0, msel = 0, rd = 0, xf = 0;
  int first_rd = -1, first_vld = -1, done_cyc = -1, start_cyc = -1;
  logic err_due = 1'b0, held = 1'b0, held_last = 1'b0;
  logic [DW-1:0] held_data;

  always @(negedge clk_1x) begin
    cyc++;
    if (rst) begin
      ph = 0; err_due = 1'b0; held = 1'b0;
    end else begin
      chk("busy", busy, ph == 1);
      chk("done", done, ph == 2);
      chk("err_tsel", err_tsel, err_due);
      if (ph != 1) begin
        chk("rd_en_idle", rom_rd_en, 0);
        chk("valid_idle", m_valid, 0);
      end
      if (held) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held_data);
        chk("hold_last", m_last, held_last);
      end
      if (done && done_cyc < 0) done_cyc = cyc;
      err_due = 1'b0;
      held = 1'b0;
      case (ph)
        0: if (start && !abort) begin
          if (t_sel == 2'd3) err_due = 1'b1;
          else begin
            ph = 1; mn = n_of(t_sel); msel = int'(t_sel); rd = 0; xf = 0;
            first_rd = -1; first_vld = -1; done_cyc = -1; start_cyc = cyc;
          end
        end
        1: begin
          if (rom_rd_en) begin
            chk("rd_credit", (rd - xf) < FD, 1);
            chk("rd_count", rd < mn, 1);
            chk("rd_addr", rom_rdaddr, exp_addr(mn, rd));
            chk("rd_sel", rom_sel, msel);
            if (first_rd < 0) first_rd = cyc;
            rd++;
          end
          if (m_valid && first_vld < 0) first_vld = cyc;
          if (m_valid && m_ready) begin
            chk("xf_count", xf < mn, 1);
            if (xf < mn) begin
              chk("data", m_data, rom_mem[msel][exp_addr(mn, xf)]);
              chk("last", m_last, xf == mn - 1);
            end
            xf++;
          end else if (m_valid) begin
            held = !abort; held_data = m_data; held_last = m_last;
          end
          if (abort) ph = 0;
          else if (xf == mn) ph = 2;
        end
        default: ph = 0;
      endcase
    end
  end

  int rmode = 0;

  task automatic step();
    @(posedge clk_1x);
    #1;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      2:       m_ready = 1'b0;
      default: m_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_start(input logic [1:0] t);
    start = 1'b1; t_sel = t;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (ph != 0 && n < 400) begin step(); n++; end
    checks++;
    if (ph != 0) begin
      errors++;
      $display("FAIL %s timeout: sequence still active after %0d cycles, expected idle", nm, n);
    end
  endtask

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 32; a++)
        rom_mem[s][a] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                         8'(s), 8'(a), 16'hA5C3};

    // Reset values
    step(); step();
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_err", err_tsel, 0);  chk("rst_rd_en", rom_rd_en, 0);
    chk("rst_valid", m_valid, 0); chk("rst_last", m_last, 0);
    chk("rst_addr", rom_rdaddr, 0); chk("rst_sel", rom_sel, 0);
    chk("rst_data", m_data, 0);
    rst = 1'b0;
    step();

    // t=12 with full-rate sink: latency and throughput pinned by hand
    rmode = 0;
    run_start(2'd2);
    wait_idle("t1");
    chk("t1_rd_lat", first_rd - start_cyc, 1);
    chk("t1_vld_lat", first_vld - first_rd, 2);
    chk("t1_done_lat", done_cyc - first_rd, 26);
    chk("t1_reads", rd, 24);
    chk("t1_words", xf, 24);
    step();

    // t=8 with toggling ready
    rmode = 1;
    run_start(2'd0);
    wait_idle("t2");
    chk("t2_words", xf, 16);
    chk("t2_reads", rd, 16);

    // t=10 with sink stalled for 10 cycles after first valid
    rmode = 2;
    run_start(2'd1);
    for (int n = 0; n < 20 && first_vld < 0; n++) step();
    for (int n = 0; n < 10; n++) step();
    chk("t3_stall_reads", rd <= 3, 1);
    chk("t3_stall_words", xf, 0);
    rmode = 0;
    wait_idle("t3");
    chk("t3_words", xf, 20);

    // abort on the 5th transfer, then a fresh run
    rmode = 0;
    run_start(2'd2);
    for (int n = 0; n < 100 && !(xf == 4 && m_valid); n++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t4_words", xf, 5);
    chk("t4_valid", m_valid, 0);
    chk("t4_busy", busy, 0);
    for (int n = 0; n < 4; n++) step();
    run_start(2'd2);
    wait_idle("t4b");
    chk("t4_fresh_words", xf, 24);

    // reserved t_sel, then start while busy
    start = 1'b1; t_sel = 2'd3;
    step();
    start = 1'b0;
    chk("t5_err", err_tsel, 1);
    chk("t5_busy", busy, 0);
    step();
    chk("t5_err_pulse", err_tsel, 0);
    rmode = 1;
    run_start(2'd0);
    for (int n = 0; n < 5; n++) step();
    start = 1'b1; t_sel = 2'd2;
    step();
    start = 1'b0;
    wait_idle("t5");
    chk("t5_words", xf, 16);
    chk("t5_sel", rom_sel, 0);

    // randomized runs with occasional abort
    for (int r = 0; r < 8; r++) begin
      rmode = 3;
      run_start(2'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) begin
        for (int n = 0, w = $urandom_range(2, 15); n < w; n++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
      end
      wait_idle("rand");
      for (int n = 0, g = $urandom_range(0, 3); n < g; n++) step();
    end

    // async reset mid-sequence
    rmode = 0;
    run_start(2'd1);
    for (int n = 0; n < 6; n++) step();
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_rd_en", rom_rd_en, 0);
    chk("arst_data", m_data, 0);
    chk("arst_sel", rom_sel, 0);
    step(); step();
    rst = 1'b0;
    step();
    run_start(2'd0);
    wait_idle("post_rst");
    chk("post_rst_words", xf, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
